shift_exec_pipe: RTL and testbench
==================================

SHIFT_EXEC_PIPE -- requirements
Module: shift_exec_pipe

Interface
REQ-001 Parameter TAG_W, default 6, width of the result tag (ROB pointer).
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 flush  input  1  kill all in-flight ops; no accept that cycle.
REQ-005 in_valid  input  1  issue offers an op.
REQ-006 in_ready  output  1  block accepts the op this cycle.
REQ-007 in_op  input  3  bit2 = 32-bit word op; bits[1:0]: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
REQ-008 in_rs1  input  64  data operand.
REQ-009 in_rs2  input  64  shift-amount operand.
REQ-010 in_tag  input  TAG_W  op tag, returned unchanged.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  writeback consumes the result.
REQ-013 out_result  output  64  shift result.
REQ-014 out_tag  output  TAG_W  tag of out_result.
REQ-015 out_illegal  output  1  op used reserved encoding.

Function
REQ-016 Two register stages SHALL exist: A (operand format), B (shift and result format); each has its own valid bit.
REQ-017 Accept SHALL occur when in_valid && in_ready; the op enters A at the next edge.
REQ-018 in_ready SHALL equal !flush && (!A_valid || A_adv), where A_adv = A_valid && (!B_valid || out_ready).
REQ-019 Stage A capture: shamt = rs2[4:0] zero-extended for word ops, rs2[5:0] otherwise; the rest of rs2 is ignored.
REQ-020 Stage A data: word SRL -> zero-extend rs1[31:0]; word SRA -> sign-extend rs1[31:0]; word SLL and all 64-bit ops -> rs1.
REQ-021 Stage A SHALL decode is_left (SLL) and is_signed (SRA) and pass them to B with the data, shamt, tag, word flag and illegal flag.
REQ-022 Between A and B, the team funnel shifter SHALL be instantiated at LG_W=6 (64 bits); its y is taken combinationally and captured into B.
REQ-023 Stage B: for word ops out_result SHALL be bits[31:0] of the shift result sign-extended to 64; 64-bit ops pass the shift result unchanged.
REQ-024 Reserved op (bits[1:0]=11): out_result = 0 and out_illegal = 1; tag and timing are the same as a legal op.
REQ-025 Latency SHALL be 2 cycles: accept at edge N gives out_valid high after edge N+2 when not stalled; throughput is 1 op/cycle.
REQ-026 While out_valid && !out_ready, out_result, out_tag and out_illegal SHALL hold stable; B is not overwritten; A holds if A_valid.
REQ-027 Results SHALL leave in accept order; no op is lost or duplicated under any out_ready pattern.
REQ-028 Simultaneous out handshake and A_adv SHALL refill B in the same edge with no bubble.
REQ-029 flush SHALL clear A_valid and B_valid at the next edge, overriding accept and advance; out_valid is 0 the cycle after flush.
REQ-030 Shift by 0 SHALL return the formatted data unchanged; SRA by 63 of a negative value SHALL return all ones.

Reset
REQ-031 With reset_n low at an edge, A_valid and B_valid SHALL clear, and out_result, out_tag and out_illegal SHALL become 0.
REQ-032 in_ready SHALL be 0 while reset_n is low; after reset in_ready is 1 and out_valid is 0.
REQ-033 Reset mid-operation SHALL discard all in-flight ops; no result for them ever appears.

Verification
REQ-034 SRA, rs1=0x8000_0000_0000_0000, rs2=63, tag 5 -> out_result=0xFFFF_FFFF_FFFF_FFFF, out_tag=5, exactly 2 cycles after accept.
REQ-035 SLLW rs1=1, rs2=31 -> 0xFFFF_FFFF_8000_0000; SRLW rs1=0xFFFF_FFFF_8000_0000, rs2=0x20 -> 0xFFFF_FFFF_8000_0000; same with rs2=1 -> 0x0000_0000_4000_0000.
REQ-036 Ops tags 1,2,3 back-to-back with out_ready=0 for 4 cycles -> in_ready drops after 2 accepts; tag 1 holds stable; on release tags 1,2,3 emerge on consecutive cycles.
REQ-037 Two ops in flight plus in_valid, with flush pulsed 1 cycle -> in_ready=0 that cycle; out_valid=0 next cycle; no result for any of the three ops.
REQ-038 Reserved op 0b011, tag 7 -> out_result=0, out_illegal=1, out_tag=7 at 2-cycle latency; the next legal op has out_illegal=0.
REQ-039 reset_n low 1 cycle with B full and out_ready=0 -> out_valid=0 and outputs 0 after the edge; a new op after reset completes normally.

Source files
------------

// File: rtl/shift_exec_pipe.sv
// Two-stage 64-bit shift execution pipe (SLL/SRL/SRA plus 32-bit word forms)
// with valid/ready handshakes, flush and in-order result delivery.

module funnel_shifter #(
    parameter  int unsigned LG_W = 6,
    localparam int unsigned W    = 1 << LG_W
) (
    input  logic [W-1:0]    hi,
    input  logic [W-1:0]    lo,
    input  logic [LG_W-1:0] shamt,
    output logic [W-1:0]    y
);
    always_comb begin
        y = W'({hi, lo} >> shamt);
    end
endmodule

module shift_exec_pipe #(
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [63:0]      in_rs1,
    input  logic [63:0]      in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);
    logic             a_valid_q, a_valid_d;
    logic [63:0]      a_data_q, a_data_d;
    logic [5:0]       a_shamt_q, a_shamt_d;
    logic             a_left_q, a_left_d;
    logic             a_signed_q, a_signed_d;
    logic             a_word_q, a_word_d;
    logic             a_illegal_q, a_illegal_d;
    logic [TAG_W-1:0] a_tag_q, a_tag_d;

    logic             b_valid_q, b_valid_d;
    logic [63:0]      b_result_q, b_result_d;
    logic [TAG_W-1:0] b_tag_q, b_tag_d;
    logic             b_illegal_q, b_illegal_d;

    logic             a_adv;
    logic             accept;
    logic [63:0]      fs_hi, fs_lo, fs_y;
    logic [5:0]       fs_shamt;
    logic             unused_rs2_hi;

    always_comb begin
        a_adv    = a_valid_q && (!b_valid_q || out_ready);
        in_ready = reset_n && !flush && (!a_valid_q || a_adv);
        accept   = in_valid && in_ready;
        unused_rs2_hi = ^in_rs2[63:6];
    end

    // Stage A: operand formatting and op decode
    always_comb begin
        a_valid_d   = a_valid_q;
        a_data_d    = a_data_q;
        a_shamt_d   = a_shamt_q;
        a_left_d    = a_left_q;
        a_signed_d  = a_signed_q;
        a_word_d    = a_word_q;
        a_illegal_d = a_illegal_q;
        a_tag_d     = a_tag_q;
        if (flush) begin
            a_valid_d = 1'b0;
        end else if (accept) begin
            a_valid_d   = 1'b1;
            a_word_d    = in_op[2];
            a_left_d    = (in_op[1:0] == 2'b00);
            a_signed_d  = (in_op[1:0] == 2'b10);
            a_illegal_d = (in_op[1:0] == 2'b11);
            a_tag_d     = in_tag;
            a_shamt_d   = in_op[2] ? {1'b0, in_rs2[4:0]} : in_rs2[5:0];
            if (in_op[2] && in_op[1:0] == 2'b01)
                a_data_d = {32'h0, in_rs1[31:0]};
            else if (in_op[2] && in_op[1:0] == 2'b10)
                a_data_d = {{32{in_rs1[31]}}, in_rs1[31:0]};
            else
                a_data_d = in_rs1;
        end else if (a_adv) begin
            a_valid_d = 1'b0;
        end
    end

    // Left shifts reuse the right funnel: pre-shift by one, then shift by ~shamt (= 63 - shamt).
    always_comb begin
        if (a_left_q) begin
            fs_hi    = {1'b0, a_data_q[63:1]};
            fs_lo    = {a_data_q[0], 63'h0};
            fs_shamt = ~a_shamt_q;
        end else begin
            fs_hi    = {64{a_signed_q & a_data_q[63]}};
            fs_lo    = a_data_q;
            fs_shamt = a_shamt_q;
        end
    end

    funnel_shifter #(.LG_W(6)) u_funnel (
        .hi    (fs_hi),
        .lo    (fs_lo),
        .shamt (fs_shamt),
        .y     (fs_y)
    );

    // Stage B: result formatting; holds while the consumer stalls
    always_comb begin
        b_valid_d   = b_valid_q;
        b_result_d  = b_result_q;
        b_tag_d     = b_tag_q;
        b_illegal_d = b_illegal_q;
        if (flush) begin
            b_valid_d = 1'b0;
        end else if (a_adv) begin
            b_valid_d   = 1'b1;
            b_tag_d     = a_tag_q;
            b_illegal_d = a_illegal_q;
            if (a_illegal_q)
                b_result_d = '0;
            else if (a_word_q)
                b_result_d = {{32{fs_y[31]}}, fs_y[31:0]};
            else
                b_result_d = fs_y;
        end else if (out_ready) begin
            b_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_valid_q   <= 1'b0;
            a_data_q    <= '0;
            a_shamt_q   <= '0;
            a_left_q    <= 1'b0;
            a_signed_q  <= 1'b0;
            a_word_q    <= 1'b0;
            a_illegal_q <= 1'b0;
            a_tag_q     <= '0;
            b_valid_q   <= 1'b0;
            b_result_q  <= '0;
            b_tag_q     <= '0;
            b_illegal_q <= 1'b0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_data_q    <= a_data_d;
            a_shamt_q   <= a_shamt_d;
            a_left_q    <= a_left_d;
            a_signed_q  <= a_signed_d;
            a_word_q    <= a_word_d;
            a_illegal_q <= a_illegal_d;
            a_tag_q     <= a_tag_d;
            b_valid_q   <= b_valid_d;
            b_result_q  <= b_result_d;
            b_tag_q     <= b_tag_d;
            b_illegal_q <= b_illegal_d;
        end
    end

    always_comb begin
        out_valid   = b_valid_q;
        out_result  = b_result_q;
        out_tag     = b_tag_q;
        out_illegal = b_illegal_q;
    end
endmodule

// File: tb/tb_shift_exec_pipe.sv
// Self-checking bench for shift_exec_pipe: directed vectors, stall/flush/reset
// sequences and randomized traffic against a queue-based reference model.

module tb_shift_exec_pipe;
    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [2:0]  in_op;
    logic [63:0] in_rs1, in_rs2, out_result;
    logic [5:0]  in_tag, out_tag;

    int checks = 0;
    int errors = 0;

    shift_exec_pipe #(.TAG_W(6)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [5:0]  tag;
        logic [63:0] exp_res;
        logic        exp_ill;
    } vec_t;

    typedef struct packed {
        logic        ill;
        logic [63:0] res;
        logic [5:0]  tag;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [5:0] t);
        in_valid = v;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = t;
    endtask

    // Reference: shift semantics straight from the ISA-level description.
    function automatic exp_t model(input logic [2:0] op, input logic [63:0] a,
                                   input logic [63:0] b, input logic [5:0] t);
        exp_t        e;
        logic [63:0] r;
        int unsigned sh;
        e.tag = t;
        e.ill = (op[1:0] == 2'b11);
        r = 64'h0;
        if (!e.ill) begin
            if (op[2]) begin
                sh = int'(b[4:0]);
                case (op[1:0])
                    2'b00:   r = a << sh;
                    2'b01:   r = {32'h0, a[31:0]} >> sh;
                    default: r = $signed({{32{a[31]}}, a[31:0]}) >>> sh;
                endcase
                r = {{32{r[31]}}, r[31:0]};
            end else begin
                sh = int'(b[5:0]);
                case (op[1:0])
                    2'b00:   r = a << sh;
                    2'b01:   r = a >> sh;
                    default: r = $signed(a) >>> sh;
                endcase
            end
        end
        e.res = r;
        return e;
    endfunction

    vec_t vecs[12];
    exp_t q[$];
    exp_t e;
    int   got_tag[$];
    int   got_cyc[$];
    logic stall_prev;
    logic [63:0] hold_res;
    logic [5:0]  hold_tag;
    logic        hold_ill;
    logic        acc3;

    initial begin
        vecs[0]  = '{3'b010, 64'h8000_0000_0000_0000, 64'd63, 6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[1]  = '{3'b100, 64'd1, 64'd31, 6'd6, 64'hFFFF_FFFF_8000_0000, 1'b0};
        vecs[2]  = '{3'b101, 64'hFFFF_FFFF_8000_0000, 64'h20, 6'd9, 64'hFFFF_FFFF_8000_0000, 1'b0};
        vecs[3]  = '{3'b101, 64'hFFFF_FFFF_8000_0000, 64'd1, 6'd10, 64'h0000_0000_4000_0000, 1'b0};
        vecs[4]  = '{3'b011, 64'h1234, 64'd3, 6'd7, 64'h0, 1'b1};
        vecs[5]  = '{3'b000, 64'd1, 64'd2, 6'd8, 64'd4, 1'b0};
        vecs[6]  = '{3'b000, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFC0, 6'd11,
                     64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[7]  = '{3'b001, 64'h8000_0000_0000_0000, 64'd63, 6'd12, 64'd1, 1'b0};
        vecs[8]  = '{3'b110, 64'h0000_0000_8000_0000, 64'd4, 6'd13, 64'hFFFF_FFFF_F800_0000, 1'b0};
        vecs[9]  = '{3'b000, 64'h0123_4567_89AB_CDEF, 64'd4, 6'd14, 64'h1234_5678_9ABC_DEF0, 1'b0};
        vecs[10] = '{3'b111, 64'hFFFF, 64'd1, 6'd3, 64'h0, 1'b1};
        vecs[11] = '{3'b001, 64'hF000_0000_0000_0000, 64'd4, 6'd63, 64'h0F00_0000_0000_0000, 1'b0};

        // Reset state
        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 3'b000, 64'h0, 64'h0, 6'h0);
        step(); step();
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", out_result, 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_illegal", 64'(out_illegal), 64'd0);
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        step();

        // Single ops with latency check
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].tag);
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
            step();
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_lat1_valid", i), 64'(out_valid), 64'd0);
            step();
            @(negedge clk);
            chk($sformatf("v%0d_lat2_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d_result", i), out_result, vecs[i].exp_res);
            chk($sformatf("v%0d_tag", i), 64'(out_tag), 64'(vecs[i].tag));
            chk($sformatf("v%0d_illegal", i), 64'(out_illegal), 64'(vecs[i].exp_ill));
            step();
        end

        // Back-pressure: tags 1,2,3 with out_ready low for 4 cycles
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 64'd1, 64'd1, 6'd1);
        @(negedge clk); chk("bp_acc1", 64'(in_ready), 64'd1); step();
        drive(1'b1, 3'b000, 64'd2, 64'd1, 6'd2);
        @(negedge clk); chk("bp_acc2", 64'(in_ready), 64'd1); step();
        drive(1'b1, 3'b000, 64'd3, 64'd1, 6'd3);
        @(negedge clk);
        chk("bp_ready_drop", 64'(in_ready), 64'd0);
        chk("bp_hold_tag_a", 64'(out_tag), 64'd1);
        chk("bp_hold_res_a", out_result, 64'd2);
        step();
        @(negedge clk);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_tag_b", 64'(out_tag), 64'd1);
        step();
        out_ready = 1'b1;
        acc3 = 1'b0;
        for (int k = 0; k < 12 && got_tag.size() < 3; k++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc3 = 1'b1;
            if (out_valid && out_ready) begin
                got_tag.push_back(int'(out_tag));
                got_cyc.push_back(k);
            end
            step();
            if (acc3) in_valid = 1'b0;
        end
        chk("bp_count", 64'(got_tag.size()), 64'd3);
        for (int k = 0; k < got_tag.size() && k < 3; k++) begin
            chk($sformatf("bp_order%0d", k), 64'(got_tag[k]), 64'(k + 1));
            if (k > 0) chk($sformatf("bp_consec%0d", k), 64'(got_cyc[k] - got_cyc[k-1]), 64'd1);
        end
        in_valid = 1'b0;
        step();

        // Flush with two ops in flight and a third offered
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 64'd5, 64'd1, 6'd20); step();
        drive(1'b1, 3'b000, 64'd6, 64'd1, 6'd21); step();
        drive(1'b1, 3'b000, 64'd7, 64'd1, 6'd22);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_in_ready", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("fl_out_valid_next", 64'(out_valid), 64'd0);
        step();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) chk("fl_ghost_result", 64'(out_tag), 64'hFFFF);
            step();
        end

        // Reset with B full and stalled
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 64'd5, 64'd1, 6'd30); step();
        drive(1'b1, 3'b001, 64'd8, 64'd1, 6'd31); step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("rm_b_full", 64'(out_valid), 64'd1);
        step();
        reset_n = 1'b0;
        @(negedge clk);
        chk("rm_in_ready_low", 64'(in_ready), 64'd0);
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rm_out_valid", 64'(out_valid), 64'd0);
        chk("rm_result", out_result, 64'd0);
        chk("rm_tag", 64'(out_tag), 64'd0);
        chk("rm_illegal", 64'(out_illegal), 64'd0);
        out_ready = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid) chk("rm_ghost_result", 64'(out_tag), 64'hFFFF);
            step();
        end
        drive(1'b1, 3'b010, 64'hFFFF_0000_0000_0000, 64'd8, 6'd17); step();
        in_valid = 1'b0; step();
        @(negedge clk);
        chk("rm_new_valid", 64'(out_valid), 64'd1);
        chk("rm_new_result", out_result, 64'hFFFF_FF00_0000_0000);
        chk("rm_new_tag", 64'(out_tag), 64'd17);
        step();

        // Randomized traffic against the queue model
        stall_prev = 1'b0;
        hold_res = '0; hold_tag = '0; hold_ill = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 63)),
                  6'($urandom));
            out_ready = $urandom_range(0, 9) < 6;
            flush = $urandom_range(0, 99) < 3;
            @(negedge clk);
            if (stall_prev) begin
                chk("rnd_hold_valid", 64'(out_valid), 64'd1);
                chk("rnd_hold_result", out_result, hold_res);
                chk("rnd_hold_tag", 64'(out_tag), 64'(hold_tag));
                chk("rnd_hold_illegal", 64'(out_illegal), 64'(hold_ill));
            end
            if (flush) chk("rnd_flush_ready", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious_result", 64'(out_tag), 64'hFFFF);
                end else begin
                    e = q.pop_front();
                    chk("rnd_result", out_result, e.res);
                    chk("rnd_tag", 64'(out_tag), 64'(e.tag));
                    chk("rnd_illegal", 64'(out_illegal), 64'(e.ill));
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_op, in_rs1, in_rs2, in_tag));
            if (flush) q.delete();
            stall_prev = out_valid && !out_ready && !flush;
            hold_res = out_result; hold_tag = out_tag; hold_ill = out_illegal;
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("drain_spurious_result", 64'(out_tag), 64'hFFFF);
                end else begin
                    e = q.pop_front();
                    chk("drain_result", out_result, e.res);
                    chk("drain_tag", 64'(out_tag), 64'(e.tag));
                end
            end
            step();
        end
        chk("drain_queue_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
